// File: rtl/cla_16bit_sub_pipe.sv
// Two-stage pipelined subtractor (num1 - num2 - b_in) built from 4-bit lookahead groups, with borrow and ALU flags.
// Optional SUB_SAT_EN adds a sat_mode input that clamps signed-overflowing results.
module cla_16bit_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             b_in,
`ifdef SUB_SAT_EN
  input  logic             sat_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int HI_W = WIDTH - SPLIT;

  // Returns {carry_out, sum[3:0]} of a + b + c0.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

`ifdef SUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] d, input logic ov,
                                                 input logic sm, input logic n1_msb);
    if (sm && ov) return {n1_msb, {(WIDTH-1){~n1_msb}}};
    return d;
  endfunction
`endif

  logic s1_valid;
  logic s2_valid;
  logic s1_ready;
  logic s2_ready;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // Stage 0 -> 1: low half, subtraction as num1 + ~num2 + !b_in
  logic [SPLIT-1:0] lo_sum;
  logic             lo_c;
  logic [4:0]       lo_grp;

  always_comb begin
    lo_sum = '0;
    lo_grp = '0;
    lo_c   = ~b_in;
    for (int g = 0; g < SPLIT / 4; g++) begin
      lo_grp            = cla4(num1[4*g +: 4], ~num2[4*g +: 4], lo_c);
      lo_sum[4*g +: 4]  = lo_grp[3:0];
      lo_c              = lo_grp[4];
    end
  end

  logic [SPLIT-1:0] diff_lo_p1;
  logic             c_mid_p1;
  logic [HI_W-1:0]  num1_hi_p1;
  logic [HI_W-1:0]  num2_hi_p1;
`ifdef SUB_SAT_EN
  logic             sat_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (s1_ready) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_ready) begin
      diff_lo_p1 <= lo_sum;
      c_mid_p1   <= lo_c;
      num1_hi_p1 <= num1[WIDTH-1:SPLIT];
      num2_hi_p1 <= num2[WIDTH-1:SPLIT];
`ifdef SUB_SAT_EN
      sat_p1     <= sat_mode;
`endif
    end
  end

  // Stage 1 -> 2: high half, borrow and flags
  logic [HI_W-1:0]  hi_sum;
  logic             hi_c;
  logic [4:0]       hi_grp;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] res_w;
  logic             ovf_w;

  always_comb begin
    hi_sum = '0;
    hi_grp = '0;
    hi_c   = c_mid_p1;
    for (int g = 0; g < HI_W / 4; g++) begin
      hi_grp           = cla4(num1_hi_p1[4*g +: 4], ~num2_hi_p1[4*g +: 4], hi_c);
      hi_sum[4*g +: 4] = hi_grp[3:0];
      hi_c             = hi_grp[4];
    end
    diff_w = {hi_sum, diff_lo_p1};
    ovf_w  = (num1_hi_p1[HI_W-1] ^ num2_hi_p1[HI_W-1]) & (diff_w[WIDTH-1] ^ num1_hi_p1[HI_W-1]);
`ifdef SUB_SAT_EN
    res_w  = sat_clamp(diff_w, ovf_w, sat_p1, num1_hi_p1[HI_W-1]);
`else
    res_w  = diff_w;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff  <= res_w;
        b_out <= ~hi_c;
        zero  <= (res_w == '0);
        neg   <= res_w[WIDTH-1];
        ovf   <= ovf_w;
      end
    end
  end

endmodule

// File: tb/tb_cla_16bit_sub_pipe.sv
// Scoreboard bench for cla_16bit_sub_pipe: directed vectors push expected results; a monitor pops on each output transfer.
module tb_cla_16bit_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] num1 = '0;
  logic [15:0] num2 = '0;
  logic        b_in = 1'b0;
  logic        sat_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        b_out, zero, neg, ovf;

  cla_16bit_sub_pipe #(.WIDTH(16), .SPLIT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .b_in(b_in),
`ifdef SUB_SAT_EN
    .sat_mode(sat_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .b_out(b_out), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  vec_t vt[0:17];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pop_cyc[0:8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops on every output transfer, checks stall stability.
  initial begin
    exp_t        e;
    logic        held_v;
    logic [15:0] held_d;
    logic [15:0] held_f;
    held_v = 1'b0;
    held_d = '0;
    held_f = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          if (held_v) begin
            check("hold_diff", diff, held_d);
            check("hold_flags", {12'h0, b_out, zero, neg, ovf}, held_f);
          end
          held_d = diff;
          held_f = {12'h0, b_out, zero, neg, ovf};
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got diff %h expected no output", diff);
          end else begin
            e = q.pop_front();
            check("diff", diff, e.d);
            check("flags(bo,z,n,o)", {12'h0, b_out, zero, neg, ovf}, {12'h0, e.bo, e.z, e.n, e.o});
            if (e.tag != 8'd0) pop_cyc[e.tag] = cyc;
          end
        end
      end
    end
  end

  task automatic send(input vec_t v, input logic sm, input logic [7:0] tag, input logic push);
    exp_t e;
    logic ok;
    e = '{v.d, v.bo, v.z, v.n, v.o, tag};
    num1 = v.a;
    num2 = v.b;
    b_in = v.bi;
    sat_mode = sm;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else if (push) begin
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
    #1;
    n = q.size();
    check("drain_left", 16'(n), 16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vsat;
    //                a         b      bi   diff     bo    z     n     o
    vt[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[12] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[14] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[15] = '{16'h8001, 16'h7FFF, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[16] = '{16'h0080, 16'h0081, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[17] = '{16'h3000, 16'h0FFF, 1'b0, 16'h2001, 1'b0, 1'b0, 1'b0, 1'b0};
    vsat   = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held 3 clk with in_valid asserted
    rst = 1'b1;
    in_valid = 1'b1;
    num1 = 16'hFFFF;
    num2 = 16'h0001;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", {15'h0, out_valid}, 16'h0);
      check("rst_flags", {12'h0, b_out, zero, neg, ovf}, 16'h0);
      check("rst_diff", diff, 16'h0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("in_ready_after_rst", {15'h0, in_ready}, 16'h1);
    @(posedge clk);
    #1;
    check("no_emit_after_rst", {15'h0, out_valid}, 16'h0);
    @(posedge clk);
    #1;
    check("no_emit_after_rst2", {15'h0, out_valid}, 16'h0);

    // Directed vectors, one at a time, with latency on the first
    send(vt[0], 1'b0, 8'd0, 1'b1);
    check("lat_after_accept", {15'h0, out_valid}, 16'h0);
    @(posedge clk);
    #1;
    check("lat_second_edge", {15'h0, out_valid}, 16'h1);
    wait_drain();
    for (int i = 1; i < 4; i++) begin
      send(vt[i], 1'b0, 8'd0, 1'b1);
      wait_drain();
    end
`ifdef SUB_SAT_EN
    send(vsat, 1'b1, 8'd0, 1'b1);
    wait_drain();
`endif

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) send(vt[4+i], 1'b0, 8'(i + 1), 1'b1);
    wait_drain();
    for (int k = 2; k <= 8; k++) check("stream_consecutive", 16'(pop_cyc[k] - pop_cyc[k-1]), 16'h1);

    // Stall for 4 clk mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) send(vt[12+i], 1'b0, 8'd0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready", {15'h0, in_ready}, 16'h0);
        check("stall_out_valid", {15'h0, out_valid}, 16'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset pulse during a stall empties the pipe
    out_ready = 1'b0;
    send(vt[0], 1'b0, 8'd0, 1'b0);
    send(vt[1], 1'b0, 8'd0, 1'b0);
    check("prefill_out_valid", {15'h0, out_valid}, 16'h1);
    check("prefill_in_ready", {15'h0, in_ready}, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("flush_out_valid", {15'h0, out_valid}, 16'h0);
    check("flush_in_ready", {15'h0, in_ready}, 16'h1);
    check("flush_diff", diff, 16'h0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_stays_empty", {15'h0, out_valid}, 16'h0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
